// File: rtl/intra_eval_sched.sv
// rtl/intra_eval_sched.sv - round-robin arbiter, start issue and done-join for the shared luma eval engine
module intra_eval_sched #(
  parameter int NUM_REQ = 3,
  parameter int TMO_W   = 12,
  parameter int TIMEOUT = 4000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rec_start,
  input  logic               rec_done,
  input  logic               sse_done,
  input  logic               disto_done,
  input  logic               cost_done,
  output logic               eval_done,
  output logic [2:0]         eval_id,
  output logic               eval_err,
  output logic               busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GRANT     = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_REC  = 3'd3;
  localparam logic [2:0] S_WAIT_JOIN = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  // wd holds TIMEOUT-2 in the last waiting cycle, so DONE lands TIMEOUT cycles after rec_start
  localparam logic [TMO_W-1:0] WD_LAST = TMO_W'(TIMEOUT - 2);
  localparam logic [3:0]       NREQ    = 4'(NUM_REQ);

  logic [2:0]         state;
  logic [2:0]         idx;
  logic [2:0]         ptr;
  logic [2:0]         flags;
  logic [TMO_W-1:0]   wd;
  logic               tmo;

  logic [NUM_REQ-1:0] req_rot;
  logic               pick_vld;
  logic [3:0]         pick_off;
  logic [3:0]         pick_sum;
  logic [2:0]         pick_idx;
  logic [3:0]         idx_inc;
  logic [2:0]         ptr_nxt;
  logic [2:0]         hits;
  logic [2:0]         merged;
  logic               joined;
  logic               wd_hit;

  always_comb begin
    req_rot  = NUM_REQ'({req, req} >> ptr);
    pick_vld = 1'b0;
    pick_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_vld = 1'b1;
        pick_off = 4'(i);
      end
    end
    pick_sum = {1'b0, ptr} + pick_off;
    if (pick_sum >= NREQ) pick_sum = pick_sum - NREQ;
    pick_idx = pick_sum[2:0];
  end

  assign idx_inc = {1'b0, idx} + 4'd1;
  assign ptr_nxt = (idx_inc >= NREQ) ? 3'd0 : idx_inc[2:0];

  // metric pulses coinciding with rec_done seed the flags rather than being dropped
  assign hits   = {cost_done, disto_done, sse_done};
  assign merged = (state == S_WAIT_JOIN) ? (flags | hits) : hits;
  assign joined = (&merged) && ((state == S_WAIT_JOIN) || ((state == S_WAIT_REC) && rec_done));
  assign wd_hit = (wd == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      ptr   <= '0;
      flags <= '0;
      wd    <= '0;
      tmo   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            idx   <= pick_idx;
            state <= S_GRANT;
          end
        end
        S_GRANT: state <= S_START;
        S_START: begin
          wd    <= '0;
          tmo   <= 1'b0;
          flags <= '0;
          state <= S_WAIT_REC;
        end
        S_WAIT_REC, S_WAIT_JOIN: begin
          if (wd != '1) wd <= wd + TMO_W'(1);
          if ((state == S_WAIT_JOIN) || rec_done) flags <= merged;
          if (joined) begin
            state <= S_DONE;
          end else if (wd_hit) begin
            tmo   <= 1'b1;
            state <= S_DONE;
          end else if ((state == S_WAIT_REC) && rec_done) begin
            state <= S_WAIT_JOIN;
          end
        end
        S_DONE: begin
          ptr   <= ptr_nxt;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign gnt       = busy ? (NUM_REQ'(1) << idx) : '0;
  assign rec_start = (state == S_START);
  assign eval_done = (state == S_DONE);
  assign eval_id   = eval_done ? idx : 3'd0;
  assign eval_err  = eval_done & tmo;

endmodule

// File: tb/tb_intra_eval_sched.sv
// tb/tb_intra_eval_sched.sv - directed bench for intra_eval_sched (TIMEOUT=100)
module tb_intra_eval_sched;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic         rec_start;
  logic         rec_done = 1'b0;
  logic         sse_done = 1'b0;
  logic         disto_done = 1'b0;
  logic         cost_done = 1'b0;
  logic         eval_done;
  logic [2:0]   eval_id;
  logic         eval_err;
  logic         busy;

  int checks = 0;
  int errors = 0;

  intra_eval_sched #(.NUM_REQ(N), .TMO_W(12), .TIMEOUT(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .rec_start  (rec_start),
    .rec_done   (rec_done),
    .sse_done   (sse_done),
    .disto_done (disto_done),
    .cost_done  (cost_done),
    .eval_done  (eval_done),
    .eval_id    (eval_id),
    .eval_err   (eval_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rec_done   = 1'b0;
    sse_done   = 1'b0;
    disto_done = 1'b0;
    cost_done  = 1'b0;
  endtask

  // Called in the IDLE cycle (cycle 0) with req already driven; returns in the IDLE cycle after DONE
  task automatic op(input string tag, input logic [2:0] exp_id,
                    input int rd_at, input int s_at, input int s2_at, input int d_at,
                    input int c_at, input int drop_at, input logic exp_err, input int exp_done);
    int         done_k  = -1;
    int         starts  = 0;
    int         start_k = -1;
    logic       gnt_ok  = 1'b1;
    logic [2:0] got_id  = 3'd7;
    logic       got_err = 1'bx;
    logic [N-1:0] exp_gnt;
    exp_gnt = N'(1) << exp_id;
    for (int k = 1; k <= 300 && done_k < 0; k++) begin
      tick();
      if (k == rd_at) rec_done = 1'b1;
      if (k == s_at || k == s2_at) sse_done = 1'b1;
      if (k == d_at) disto_done = 1'b1;
      if (k == c_at) cost_done = 1'b1;
      if (k == drop_at) req = '0;
      if (rec_start) begin
        starts++;
        start_k = k;
      end
      if (gnt !== exp_gnt || busy !== 1'b1) gnt_ok = 1'b0;
      if (eval_done === 1'b1) begin
        done_k  = k;
        got_id  = eval_id;
        got_err = eval_err;
      end
    end
    chk({tag, ":start_cycle"}, start_k, 2);
    chk({tag, ":start_count"}, starts, 1);
    chk({tag, ":gnt_stable"}, gnt_ok, 1);
    chk({tag, ":done_cycle"}, done_k, exp_done);
    chk({tag, ":eval_id"}, got_id, exp_id);
    chk({tag, ":eval_err"}, got_err, exp_err);
    tick();
    chk({tag, ":idle_after"}, {gnt, busy, eval_done}, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {gnt, rec_start, eval_done, eval_id, eval_err, busy}, 0);
    rst = 1'b0;

    req = 3'b001;
    op("single", 3'd0, 10, 40, -1, 55, 70, -1, 1'b0, 71);
    req = 3'b000;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 3'b111;
    op("rr0", 3'd0, 3, 4, -1, 5, 6, -1, 1'b0, 7);
    op("rr1", 3'd1, 3, 4, -1, 5, 6, -1, 1'b0, 7);
    op("rr2", 3'd2, 3, 4, -1, 5, 6, -1, 1'b0, 7);
    op("rr3", 3'd0, 3, 6, -1, 4, 5, -1, 1'b0, 7);
    op("rr4", 3'd1, 3, 5, -1, 6, 4, -1, 1'b0, 7);
    op("rr5", 3'd2, 3, 4, -1, 4, 4, -1, 1'b0, 5);

    req = 3'b001;
    op("same_cycle", 3'd0, 3, 3, -1, 3, 3, -1, 1'b0, 4);
    op("dup_sse", 3'd0, 3, 4, 6, 5, 8, -1, 1'b0, 9);

    op("timeout", 3'd0, 3, 4, -1, 5, -1, -1, 1'b1, 102);
    op("after_tmo", 3'd0, 3, 4, -1, 5, 6, -1, 1'b0, 7);

    req = 3'b010;
    tick();
    chk("rst_grant", gnt, 3'b010);
    tick();
    tick();
    rec_done = 1'b1;
    tick();
    sse_done = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_async", {gnt, rec_start, eval_done, eval_id, eval_err, busy}, 0);
    req = 3'b000;
    tick();
    rst = 1'b0;
    disto_done = 1'b1;
    tick();
    chk("stray_disto_idle", {busy, eval_done}, 0);
    req = 3'b100;
    op("post_rst", 3'd2, 3, 4, -1, 8, 5, -1, 1'b0, 9);

    req = 3'b010;
    op("drop_req", 3'd1, 6, 7, -1, 7, 8, 4, 1'b0, 9);
    req = 3'b111;
    op("ptr_adv", 3'd2, 3, 4, -1, 5, 6, -1, 1'b0, 7);
    req = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
